// File: rtl/tile_fetch.sv
// Tile-map fetch: turns the current pixel into a tile-map read, drives the sprite map and
// registers its RGB for VGA. Optional grid overlay on blank tiles: TILE_FETCH_GRID_OVERLAY_EN.
module tile_fetch #(
   parameter int unsigned        H_TILES    = 28,
   parameter int unsigned        V_TILES    = 31,
   parameter int unsigned        CODE_W     = 4,
   parameter logic [CODE_W-1:0]  BLANK_CODE = CODE_W'(4'hF)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [9:0]        px,
   input  logic [9:0]        py,
   input  logic              de_in,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [4:0]        wr_tx,
   input  logic [4:0]        wr_ty,
   input  logic [CODE_W-1:0] wr_code,
   output logic [2:0]        spr_x,
   output logic [2:0]        spr_y,
   output logic [CODE_W-1:0] spr_code,
   input  logic [3:0]        R_in,
   input  logic [3:0]        G_in,
   input  logic [3:0]        B_in,
   output logic [3:0]        vga_r,
   output logic [3:0]        vga_g,
   output logic [3:0]        vga_b,
   output logic              de_out,
   output logic              init_done
);

   localparam int unsigned      DEPTH     = H_TILES * V_TILES;
   localparam int unsigned      AW        = $clog2(DEPTH);
   localparam logic [AW-1:0]    LAST_ADDR = AW'(DEPTH - 1);
   localparam logic [9:0]       PX_LIM    = 10'(H_TILES * 8);
   localparam logic [9:0]       PY_LIM    = 10'(V_TILES * 8);
   localparam logic [4:0]       WTX_LIM   = 5'(H_TILES);
   localparam logic [4:0]       WTY_LIM   = 5'(V_TILES);

   localparam logic [0:0] ST_CLEAR = 1'b0;
   localparam logic [0:0] ST_RUN   = 1'b1;

   logic [0:0]    state_q, state_d;
   logic [AW-1:0] clr_addr_q, clr_addr_d;
   logic          run;

   always_comb begin
      state_d    = state_q;
      clr_addr_d = clr_addr_q;
      case (state_q)
         ST_CLEAR: begin
            if (clr_addr_q == LAST_ADDR) begin
               state_d    = ST_RUN;
               clr_addr_d = '0;
            end else begin
               clr_addr_d = clr_addr_q + AW'(1);
            end
         end
         ST_RUN:  state_d = ST_RUN;
         default: begin
            state_d    = ST_CLEAR;
            clr_addr_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_CLEAR;
         clr_addr_q <= '0;
      end else begin
         state_q    <= state_d;
         clr_addr_q <= clr_addr_d;
      end
   end

   assign run       = (state_q == ST_RUN);
   assign wr_ready  = run;
   assign init_done = run;

   // Write port: the clear sweep owns the RAM until RUN; off-map writes are accepted but dropped.
   logic              wr_in_map;
   logic [AW-1:0]     wr_addr;
   logic              ram_we;
   logic [AW-1:0]     ram_waddr;
   logic [CODE_W-1:0] ram_wdata;

   assign wr_in_map = (wr_tx < WTX_LIM) && (wr_ty < WTY_LIM);
   assign wr_addr   = AW'(wr_ty * H_TILES + wr_tx);

   always_comb begin
      if (run) begin
         ram_we    = wr_valid && wr_in_map;
         ram_waddr = wr_addr;
         ram_wdata = wr_code;
      end else begin
         ram_we    = 1'b1;
         ram_waddr = clr_addr_q;
         ram_wdata = BLANK_CODE;
      end
   end

   // Read address for the current pixel; off-map pixels park on address 0 and are masked later.
   logic [6:0]    tile_x, tile_y;
   logic          px_in_map;
   logic [AW-1:0] rd_addr;

   assign tile_x    = px[9:3];
   assign tile_y    = py[9:3];
   assign px_in_map = (px < PX_LIM) && (py < PY_LIM);
   assign rd_addr   = px_in_map ? AW'(tile_y * H_TILES + tile_x) : '0;

   // Tile RAM: no reset on the array, read-first on a same-address collision.
   logic [CODE_W-1:0] mem [DEPTH];
   logic [CODE_W-1:0] rd_code_q;

   always_ff @(posedge clk) begin
      if (ram_we) begin
         mem[ram_waddr] <= ram_wdata;
      end
      rd_code_q <= mem[rd_addr];
   end

   // Stage 1: sprite-local coordinates, display enable and a RUN-qualified in-map flag.
   logic [2:0] sx_q, sy_q;
   logic       de1_q;
   logic       inr1_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sx_q   <= 3'd0;
         sy_q   <= 3'd0;
         de1_q  <= 1'b0;
         inr1_q <= 1'b0;
      end else begin
         sx_q   <= px[2:0];
         sy_q   <= py[2:0];
         de1_q  <= de_in;
         inr1_q <= px_in_map && run;
      end
   end

   assign spr_x    = sx_q;
   assign spr_y    = sy_q;
   assign spr_code = inr1_q ? rd_code_q : BLANK_CODE;

   // Stage 2: registered pixel colour; blanking and off-map pixels are forced black.
   logic [3:0] pix_r_d, pix_g_d, pix_b_d;

`ifdef TILE_FETCH_GRID_OVERLAY_EN
   logic grid_px;
   assign grid_px = (spr_code == BLANK_CODE) && ((sx_q == 3'd0) || (sy_q == 3'd0));
`endif

   always_comb begin
      pix_r_d = 4'h0;
      pix_g_d = 4'h0;
      pix_b_d = 4'h0;
      if (de1_q && inr1_q) begin
`ifdef TILE_FETCH_GRID_OVERLAY_EN
         if (grid_px) begin
            pix_r_d = 4'h3;
            pix_g_d = 4'h3;
            pix_b_d = 4'h3;
         end else begin
            pix_r_d = R_in;
            pix_g_d = G_in;
            pix_b_d = B_in;
         end
`else
         pix_r_d = R_in;
         pix_g_d = G_in;
         pix_b_d = B_in;
`endif
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vga_r  <= 4'h0;
         vga_g  <= 4'h0;
         vga_b  <= 4'h0;
         de_out <= 1'b0;
      end else begin
         vga_r  <= pix_r_d;
         vga_g  <= pix_g_d;
         vga_b  <= pix_b_d;
         de_out <= de1_q;
      end
   end

endmodule

// File: tb/tb_tile_fetch.sv
// Self-checking bench for tile_fetch: vector table plus tile-map model feeding a scoreboard.
module tb_tile_fetch;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [9:0] px, py;
   logic       de_in;
   logic       wr_valid;
   logic       wr_ready;
   logic [4:0] wr_tx, wr_ty;
   logic [3:0] wr_code;
   logic [2:0] spr_x, spr_y;
   logic [3:0] spr_code;
   logic [3:0] r_in, g_in, b_in;
   logic [3:0] vga_r, vga_g, vga_b;
   logic       de_out;
   logic       init_done;

`ifdef TILE_FETCH_GRID_OVERLAY_EN
   localparam bit GRID_EN = 1'b1;
`else
   localparam bit GRID_EN = 1'b0;
`endif
   localparam logic [3:0] GRID = GRID_EN ? 4'h3 : 4'h0;

   always #5 clk = ~clk;

   tile_fetch dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .px       (px),
      .py       (py),
      .de_in    (de_in),
      .wr_valid (wr_valid),
      .wr_ready (wr_ready),
      .wr_tx    (wr_tx),
      .wr_ty    (wr_ty),
      .wr_code  (wr_code),
      .spr_x    (spr_x),
      .spr_y    (spr_y),
      .spr_code (spr_code),
      .R_in     (r_in),
      .G_in     (g_in),
      .B_in     (b_in),
      .vga_r    (vga_r),
      .vga_g    (vga_g),
      .vga_b    (vga_b),
      .de_out   (de_out),
      .init_done(init_done)
   );

   // Sprite map stand-in: blank code is black, otherwise R=F, G=code, B=sprite-local y.
   assign r_in = (spr_code == 4'hF) ? 4'h0 : 4'hF;
   assign g_in = (spr_code == 4'hF) ? 4'h0 : spr_code;
   assign b_in = (spr_code == 4'hF) ? 4'h0 : {1'b0, spr_y};

   typedef struct {
      string      name;
      int         cyc;
      logic [2:0] sx, sy;
      logic [3:0] code, r, g, b;
      logic       de;
   } exp_t;

   typedef struct {
      string      name;
      logic       wv;
      logic [4:0] tx, ty;
      logic [3:0] wc;
      logic [9:0] x, y;
      logic       de;
      logic [2:0] sx, sy;
      logic [3:0] code, r, g, b;
      logic       eo_de;
   } vec_t;

   int   checks = 0;
   int   passed = 0;
   int   cyc = 0;
   bit   mon_en = 1'b0;
   exp_t q1[$];
   exp_t q2[$];
   exp_t none;
   logic [3:0] tmap [868];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act === req) passed++;
      else $display("FAIL %s: got %0h required %0h (t=%0t)", nm, act, req, $time);
   endtask

   function automatic exp_t model(input logic [9:0] x, input logic [9:0] y, input logic d);
      exp_t e;
      logic inr;
      logic [3:0] c;
      inr = (x < 10'd224) && (y < 10'd248);
      c = inr ? tmap[int'(y[9:3]) * 28 + int'(x[9:3])] : 4'hF;
      e.name = "scan"; e.cyc = 0; e.sx = x[2:0]; e.sy = y[2:0]; e.code = c; e.de = d;
      e.r = 4'h0; e.g = 4'h0; e.b = 4'h0;
      if (d && inr) begin
         if (GRID_EN && c == 4'hF && (x[2:0] == 3'd0 || y[2:0] == 3'd0)) begin
            e.r = 4'h3; e.g = 4'h3; e.b = 4'h3;
         end else if (c != 4'hF) begin
            e.r = 4'hF; e.g = c; e.b = {1'b0, y[2:0]};
         end
      end
      return e;
   endfunction

   // Scoreboard: stage-1 outputs one cycle after drive, stage-2 outputs two cycles after.
   always @(negedge clk) begin
      exp_t e;
      if (mon_en) begin
         if (q1.size() > 0 && q1[0].cyc == cyc - 1) begin
            e = q1.pop_front();
            chk({e.name, ".spr"}, {spr_x, spr_y, spr_code}, {e.sx, e.sy, e.code});
         end
         if (q2.size() > 0 && q2[0].cyc == cyc - 2) begin
            e = q2.pop_front();
            chk({e.name, ".vga"}, {vga_r, vga_g, vga_b, 3'b0, de_out},
                {e.r, e.g, e.b, 3'b0, e.de});
         end
      end
   end

   task automatic step(input logic wv, input logic [4:0] tx, input logic [4:0] ty,
                       input logic [3:0] wc, input logic [9:0] x, input logic [9:0] y,
                       input logic d, input bit use_te, input exp_t te);
      exp_t e;
      @(negedge clk);
      wr_valid = wv; wr_tx = tx; wr_ty = ty; wr_code = wc;
      px = x; py = y; de_in = d;
      e = use_te ? te : model(x, y, d);
      e.cyc = cyc;
      q1.push_back(e);
      q2.push_back(e);
      if (wv) begin
         chk("wr_ready_run", wr_ready, 1);
         if (tx < 5'd28 && ty < 5'd31) tmap[int'(ty) * 28 + int'(tx)] = wc;
      end
   endtask

   task automatic drain();
      @(negedge clk);
      wr_valid = 1'b0; de_in = 1'b0;
      for (int i = 0; i < 4 && q2.size() != 0; i++) begin
         @(negedge clk);
         #1;
      end
      chk("drain", q2.size() + q1.size(), 0);
   endtask

   task automatic scan();
      for (int ty = 0; ty < 33; ty++)
         for (int tx = 0; tx < 30; tx++)
            step(1'b0, 5'd0, 5'd0, 4'd0, 10'(tx * 8 + (tx + ty) % 8),
                 10'(ty * 8 + (tx * 3 + ty) % 8), 1'b1, 1'b0, none);
      drain();
   endtask

   // Counts edges from reset release until init_done; wr_ready must stay low meanwhile.
   task automatic wait_init(input string nm);
      int n = 0;
      bit early = 1'b0;
      while (!init_done && n < 2000) begin
         @(posedge clk);
         #1;
         n++;
         if (!init_done && wr_ready) early = 1'b1;
         if (n == 100) begin
            chk({nm, ".clear_vga"}, {vga_r, vga_g, vga_b}, 12'h0);
            chk({nm, ".clear_de"}, de_out, de_in);
         end
      end
      chk({nm, ".cycles"}, n, 868);
      chk({nm, ".wr_ready_clear"}, early, 0);
      chk({nm, ".wr_ready_up"}, wr_ready, 1);
   endtask

   task automatic reset_map();
      for (int i = 0; i < 868; i++) tmap[i] = 4'hF;
   endtask

   vec_t tbl[10];

   initial begin
      tbl[0] = '{"wr_2_1",       1'b1, 5'd2,  5'd1, 4'h0, 10'd0,   10'd0,   1'b0,
                 3'd0, 3'd0, 4'hF, 4'h0, 4'h0, 4'h0, 1'b0};
      tbl[1] = '{"px21_py13",    1'b0, 5'd0,  5'd0, 4'h0, 10'd21,  10'd13,  1'b1,
                 3'd5, 3'd5, 4'h0, 4'hF, 4'h0, 4'h5, 1'b1};
      tbl[2] = '{"offx_wr_tx28", 1'b1, 5'd28, 5'd0, 4'h0, 10'd224, 10'd0,   1'b1,
                 3'd0, 3'd0, 4'hF, 4'h0, 4'h0, 4'h0, 1'b1};
      tbl[3] = '{"offy_248",     1'b0, 5'd0,  5'd0, 4'h0, 10'd0,   10'd248, 1'b1,
                 3'd0, 3'd0, 4'hF, 4'h0, 4'h0, 4'h0, 1'b1};
      tbl[4] = '{"tile_0_1",     1'b0, 5'd0,  5'd0, 4'h0, 10'd3,   10'd10,  1'b1,
                 3'd3, 3'd2, 4'hF, 4'h0, 4'h0, 4'h0, 1'b1};
      tbl[5] = '{"rdfirst_old",  1'b1, 5'd0,  5'd0, 4'h0, 10'd0,   10'd0,   1'b1,
                 3'd0, 3'd0, 4'hF, GRID, GRID, GRID, 1'b1};
      tbl[6] = '{"rdfirst_new",  1'b0, 5'd0,  5'd0, 4'h0, 10'd0,   10'd0,   1'b1,
                 3'd0, 3'd0, 4'h0, 4'hF, 4'h0, 4'h0, 1'b1};
      tbl[7] = '{"grid_8_3",     1'b0, 5'd0,  5'd0, 4'h0, 10'd8,   10'd3,   1'b1,
                 3'd0, 3'd3, 4'hF, GRID, GRID, GRID, 1'b1};
      tbl[8] = '{"grid_9_3",     1'b0, 5'd0,  5'd0, 4'h0, 10'd9,   10'd3,   1'b1,
                 3'd1, 3'd3, 4'hF, 4'h0, 4'h0, 4'h0, 1'b1};
      tbl[9] = '{"blank_de0",    1'b0, 5'd0,  5'd0, 4'h0, 10'd21,  10'd13,  1'b0,
                 3'd5, 3'd5, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0};

      rst_n = 1'b0; px = '0; py = '0; de_in = 1'b0;
      wr_valid = 1'b0; wr_tx = '0; wr_ty = '0; wr_code = '0;
      repeat (3) @(negedge clk);
      chk("rst.vga", {vga_r, vga_g, vga_b}, 12'h0);
      chk("rst.de_out", de_out, 0);
      chk("rst.spr_xy", {spr_x, spr_y}, 6'h0);
      chk("rst.spr_code", spr_code, 4'hF);
      chk("rst.wr_ready", wr_ready, 0);
      chk("rst.init_done", init_done, 0);

      px = 10'd21; py = 10'd13; de_in = 1'b1;
      rst_n = 1'b1;
      wait_init("init");
      reset_map();
      mon_en = 1'b1;
      scan();

      for (int i = 0; i < 10; i++) begin
         exp_t te;
         te.name = tbl[i].name; te.cyc = 0; te.sx = tbl[i].sx; te.sy = tbl[i].sy;
         te.code = tbl[i].code; te.r = tbl[i].r; te.g = tbl[i].g; te.b = tbl[i].b;
         te.de = tbl[i].eo_de;
         step(tbl[i].wv, tbl[i].tx, tbl[i].ty, tbl[i].wc, tbl[i].x, tbl[i].y, tbl[i].de,
              1'b1, te);
      end
      drain();
      scan();

      for (int i = 0; i < 60; i++)
         step(1'b1, 5'($urandom_range(0, 29)), 5'($urandom_range(0, 31)),
              4'($urandom_range(0, 15)), 10'($urandom_range(0, 239)),
              10'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'b0, none);
      drain();
      scan();

      // Asynchronous reset mid-scan while the output is lit.
      step(1'b1, 5'd2, 5'd1, 4'h0, 10'd0, 10'd0, 1'b0, 1'b0, none);
      drain();
      mon_en = 1'b0;
      @(negedge clk);
      px = 10'd21; py = 10'd13; de_in = 1'b1;
      repeat (3) @(negedge clk);
      chk("pre_rst.vga_r", vga_r, 4'hF);
      chk("pre_rst.de_out", de_out, 1);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst.vga", {vga_r, vga_g, vga_b}, 12'h0);
      chk("async_rst.de_out", de_out, 0);
      chk("async_rst.spr_code", spr_code, 4'hF);
      chk("async_rst.init_done", init_done, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Reset again midway through the clear sweep.
      repeat (400) @(posedge clk);
      #1 chk("mid_clear.init_done", init_done, 0);
      #1 rst_n = 1'b0;
      #1 chk("mid_clear_rst.spr", {spr_x, spr_y, spr_code}, {3'd0, 3'd0, 4'hF});
      @(negedge clk);
      rst_n = 1'b1;
      wait_init("reinit");
      reset_map();
      mon_en = 1'b1;
      scan();

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
